// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and forwarding control for a classic five-stage pipeline.
// Shadows the EX/MEM/WB stages to decide load-use stalls and operand bypass selects.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_mem2reg,
  input  logic        id_memwrite,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        fwd_mem,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       mem2reg;
    logic       memwrite;
  } stage_t;

  stage_t id_s, ex_q, mem_q, wb_q;
  logic   ex_load, hit_rs, hit_rt, store_data_only;
  logic   unused_wb;

  // Register 0 is hardwired, so it never counts as a produced value.
  function automatic logic writes(stage_t s, logic [4:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] r, stage_t ex, stage_t mem, stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.valid) begin
      if (writes(mem, r) && !mem.mem2reg)
        sel = 2'b10;
      else if (writes(wb, r))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    id_s          = '0;
    id_s.valid    = 1'b1;
    id_s.rs       = id_rs;
    id_s.rt       = id_rt;
    id_s.dst      = id_dst;
    id_s.regwrite = id_regwrite;
    id_s.mem2reg  = id_mem2reg;
    id_s.memwrite = id_memwrite;
  end

  // A store whose only dependency on the EX load is its data operand is
  // served later by the MEM-stage bypass, so it proceeds without stalling.
  always_comb begin
    ex_load         = ex_q.valid && ex_q.mem2reg && (ex_q.dst != 5'd0);
    hit_rs          = id_use_rs && (id_rs == ex_q.dst);
    hit_rt          = id_use_rt && (id_rt == ex_q.dst);
    store_data_only = id_memwrite && hit_rt && !hit_rs;
    stall           = !flush && id_valid && ex_load && (hit_rs || hit_rt) && !store_data_only;
    bubble          = stall || flush;
    fwd_a           = fwd_sel(ex_q.rs, ex_q, mem_q, wb_q);
    fwd_b           = fwd_sel(ex_q.rt, ex_q, mem_q, wb_q);
    fwd_mem         = mem_q.valid && mem_q.memwrite && (mem_q.rt != 5'd0) &&
                      wb_q.mem2reg && writes(wb_q, mem_q.rt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (id_valid && !stall && !flush) ? id_s : '0;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.memwrite};

endmodule
